// File: rtl/meas_pkg.sv
// Shared measurement-mux constants and the scan controller state encoding.
// Default sizes here must track the measurement mux that meas_scan_ctrl drives.
package meas_pkg;

    localparam int C_INUM_DEF    = 48;
    localparam int C_IDWIDTH_DEF = 24;
    localparam int C_ISWIDTH_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_OUTPUT  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/meas_settle_cnt.sv
// Settle counter: synchronous load-to-zero, count-enable, terminal flag at C_SETTLE-1.
// Zero latency on the flag (decoded from the register); no backpressure, load wins over enable.
module meas_settle_cnt #(
    parameter int C_SETTLE = 4,
    parameter int C_CWIDTH = 4
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_load,
    input  logic I_en,
    output logic O_tc
);

    localparam logic [C_CWIDTH-1:0] LP_TC = C_CWIDTH'((C_SETTLE == 0) ? 0 : C_SETTLE - 1);

    logic [C_CWIDTH-1:0] r_cnt;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_cnt <= '0;
        end else if (I_load) begin
            r_cnt <= '0;
        end else if (I_en) begin
            r_cnt <= r_cnt + C_CWIDTH'(1);
        end
    end

    assign O_tc = (r_cnt == LP_TC);

endmodule

// File: rtl/meas_scan_ctrl.sv
// Mux sweep sequencer: start -> per channel settle C_SETTLE, capture, hold on valid/ready until accepted.
// First beat C_SETTLE+1 edges after the start edge; stalls indefinitely on !I_ready. MEAS_SCAN_MAXTRACK_EN adds max tracking.
module meas_scan_ctrl
    import meas_pkg::*;
#(
    parameter int C_INUM    = C_INUM_DEF,
    parameter int C_IDWIDTH = C_IDWIDTH_DEF,
    parameter int C_ISWIDTH = C_ISWIDTH_DEF,
    parameter int C_SETTLE  = 4,
    parameter int C_CWIDTH  = 4
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_start,
    input  logic                 I_abort,
    input  logic [C_IDWIDTH-1:0] I_mux_data,
    output logic [C_ISWIDTH-1:0] O_sel,
    output logic [C_IDWIDTH-1:0] O_data,
    output logic [C_ISWIDTH-1:0] O_idx,
    output logic                 O_valid,
    input  logic                 I_ready,
    output logic                 O_busy,
    output logic                 O_done
`ifdef MEAS_SCAN_MAXTRACK_EN
    ,
    output logic [C_IDWIDTH-1:0] O_max,
    output logic [C_ISWIDTH-1:0] O_max_idx
`endif
);

    localparam logic [C_ISWIDTH-1:0] LP_LAST  = C_ISWIDTH'(C_INUM - 1);
    localparam state_t               LP_FIRST = (C_SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

    state_t                 r_state;
    state_t                 w_nxt;
    logic [C_ISWIDTH-1:0]   r_sel;
    logic [C_IDWIDTH-1:0]   r_data;
    logic [C_ISWIDTH-1:0]   r_idx;
    logic                   r_valid;
    logic                   w_hs;
    logic                   w_last;
    logic                   w_go;
    logic                   w_abort;
    logic                   w_tc;
    logic                   w_cnt_load;
    logic                   w_cnt_en;

    assign w_hs    = r_valid & I_ready;
    assign w_last  = (r_sel == LP_LAST);
    assign w_abort = I_abort & (r_state != ST_IDLE);
    // A start that coincides with abort is dropped even in IDLE.
    assign w_go    = (r_state == ST_IDLE) & I_start & ~I_abort;

    meas_settle_cnt #(
        .C_SETTLE (C_SETTLE),
        .C_CWIDTH (C_CWIDTH)
    ) u_settle_cnt (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_load (w_cnt_load),
        .I_en   (w_cnt_en),
        .O_tc   (w_tc)
    );

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        if (I_abort) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (I_start) w_nxt = LP_FIRST;
                ST_SETTLE:  if (w_tc) w_nxt = ST_CAPTURE;
                ST_CAPTURE: w_nxt = ST_OUTPUT;
                ST_OUTPUT:  if (w_hs) w_nxt = w_last ? ST_DONE : LP_FIRST;
                ST_DONE:    w_nxt = ST_IDLE;
                default:    w_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        O_busy     = (r_state != ST_IDLE);
        O_done     = (r_state == ST_DONE);
        w_cnt_en   = (r_state == ST_SETTLE);
        w_cnt_load = w_go | w_abort | ((r_state == ST_OUTPUT) & w_hs & ~w_last);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_sel   <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (w_abort) begin
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) r_sel <= '0;
                end
                ST_CAPTURE: begin
                    r_data  <= I_mux_data;
                    r_idx   <= r_sel;
                    r_valid <= 1'b1;
                end
                ST_OUTPUT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (!w_last) r_sel <= r_sel + C_ISWIDTH'(1);
                    end
                end
                ST_DONE: begin
                    r_sel <= '0;
                end
                default: begin
                    r_sel <= r_sel;
                end
            endcase
        end
    end

    assign O_sel   = r_sel;
    assign O_data  = r_data;
    assign O_idx   = r_idx;
    assign O_valid = r_valid;

`ifdef MEAS_SCAN_MAXTRACK_EN
    logic [C_IDWIDTH-1:0] r_max;
    logic [C_ISWIDTH-1:0] r_max_idx;

    // Strict greater-than keeps the earlier (lower) index on ties, since channels sweep upward.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (w_go) begin
            r_max     <= '0;
            r_max_idx <= '0;
        end else if ((r_state == ST_CAPTURE) && !w_abort && (I_mux_data > r_max)) begin
            r_max     <= I_mux_data;
            r_max_idx <= r_sel;
        end
    end

    assign O_max     = r_max;
    assign O_max_idx = r_max_idx;
`endif

endmodule

// File: tb/tb_meas_scan_ctrl.sv
// Scoreboarded bench for meas_scan_ctrl: a channel-array mux model, expected beat queue and negedge monitor.
module tb_meas_scan_ctrl;

    localparam int N  = 48;
    localparam int DW = 24;
    localparam int SW = 6;
    localparam int TB_SETTLE = 4;

    typedef struct {
        logic [SW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b1;
    logic [DW-1:0] mux_data;
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic [SW-1:0] idx;
    logic          valid, busy, done;

    logic          start0 = 1'b0;
    logic [DW-1:0] mux_data0;
    logic [SW-1:0] sel0, idx0;
    logic [DW-1:0] data0;
    logic          valid0, busy0, done0;

`ifdef MEAS_SCAN_MAXTRACK_EN
    logic [DW-1:0] omax, omax0;
    logic [SW-1:0] omax_idx, omax_idx0;
`endif

    logic [DW-1:0] mem [N];
    beat_t         expq[$];
    logic [DW-1:0] exp_max;
    logic [SW-1:0] exp_max_idx;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            done_cnt = 0;
    int            rdy_mode = 0;

    always #5 clk = ~clk;

    always_comb mux_data  = mem[sel];
    always_comb mux_data0 = mem[sel0];

    meas_scan_ctrl #(.C_INUM(N), .C_IDWIDTH(DW), .C_ISWIDTH(SW), .C_SETTLE(TB_SETTLE), .C_CWIDTH(4)) u_dut (
        .I_clk(clk), .I_rst(rst), .I_start(start), .I_abort(abort), .I_mux_data(mux_data),
        .O_sel(sel), .O_data(data), .O_idx(idx), .O_valid(valid), .I_ready(ready),
        .O_busy(busy), .O_done(done)
`ifdef MEAS_SCAN_MAXTRACK_EN
        , .O_max(omax), .O_max_idx(omax_idx)
`endif
    );

    meas_scan_ctrl #(.C_INUM(N), .C_IDWIDTH(DW), .C_ISWIDTH(SW), .C_SETTLE(0), .C_CWIDTH(4)) u_dut0 (
        .I_clk(clk), .I_rst(rst), .I_start(start0), .I_abort(1'b0), .I_mux_data(mux_data0),
        .O_sel(sel0), .O_data(data0), .O_idx(idx0), .O_valid(valid0), .I_ready(1'b1),
        .O_busy(busy0), .O_done(done0)
`ifdef MEAS_SCAN_MAXTRACK_EN
        , .O_max(omax0), .O_max_idx(omax_idx0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a beat is consumed at the next edge when valid&ready and no abort overrides it.
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (valid && ready && !abort) begin
                if (expq.size() == 0) begin
                    chk("beat_unexpected_idx", 32'(idx), 32'hFFFF_FFFF);
                end else begin
                    b = expq.pop_front();
                    chk("beat_idx", 32'(idx), 32'(b.idx));
                    chk("beat_data", 32'(data), 32'(b.data));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_queue_empty", 32'(expq.size()), 0);
`ifdef MEAS_SCAN_MAXTRACK_EN
                chk("max_value", 32'(omax), 32'(exp_max));
                chk("max_index", 32'(omax_idx), 32'(exp_max_idx));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       ready = 1'b1;
            1:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    endtask

    task automatic push_scan();
        exp_max = '0;
        exp_max_idx = '0;
        for (int i = 0; i < N; i++) begin
            expq.push_back('{SW'(i), mem[i]});
            if (mem[i] > exp_max) begin
                exp_max = mem[i];
                exp_max_idx = SW'(i);
            end
        end
    endtask

    task automatic start_scan(output int lat);
        push_scan();
        start = 1'b1;
        lat = 0;
        do begin
            step();
            start = 1'b0;
            lat++;
        end while (!valid && lat < 60);
    endtask

    task automatic wait_done(input bit poke);
        int d0 = done_cnt;
        int n = 0;
        while (n < 4000) begin
            step();
            n++;
            if (done_cnt != d0) break;
            if (poke) start = ($urandom_range(0, 5) == 0);
        end
        start = 1'b0;
        repeat (3) step();
        chk("done_pulses", done_cnt - d0, 1);
        chk("idle_after_done", 32'(busy), 0);
        chk("sel_after_done", 32'(sel), 0);
        chk("queue_drained", 32'(expq.size()), 0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) mem[i] = DW'(32'h100000 + i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        mem[$urandom_range(24, N - 1)] = mem[$urandom_range(0, 23)];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0, n, cnt;
        fill_ramp();
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef MEAS_SCAN_MAXTRACK_EN
        chk("rst_max", 32'(omax), 0);
        chk("rst_max_idx", 32'(omax_idx), 0);
`endif
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // Ramp data, ready always high.
        rdy_mode = 0;
        start_scan(lat);
        chk("first_valid_latency", lat, TB_SETTLE + 2);
        wait_done(1'b0);

        // Backpressure on beat 5.
        start_scan(lat);
        n = 0;
        while (!(sel == 5 && !valid) && n < 500) begin step(); n++; end
        rdy_mode = 2;
        ready = 1'b0;
        n = 0;
        while (!valid && n < 50) begin step(); n++; end
        for (int c = 0; c < 10; c++) begin
            step();
            chk("stall_valid", 32'(valid), 1);
            chk("stall_data", 32'(data), 32'h100005);
            chk("stall_idx", 32'(idx), 5);
            chk("stall_sel", 32'(sel), 5);
        end
        rdy_mode = 0;
        ready = 1'b1;
        wait_done(1'b0);

        // Abort while settling channel 20.
        start_scan(lat);
        n = 0;
        while (!(sel == 20 && !valid) && n < 1000) begin step(); n++; end
        chk("abort_reach_ch20", 32'(sel), 20);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sel", 32'(sel), 0);
        chk("abort_valid", 32'(valid), 0);
        expq.delete();
        d0 = done_cnt;
        repeat (20) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_stays_idle", 32'(busy), 0);

        // Restart after abort with random data/ready and start poked while busy.
        rdy_mode = 1;
        for (int s = 0; s < 3; s++) begin
            fill_rand();
            start_scan(lat);
            wait_done(1'b1);
        end

        // Start together with abort in IDLE is dropped.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);
        repeat (10) step();
        chk("start_abort_valid", 32'(valid), 0);
        chk("start_abort_busy_later", 32'(busy), 0);

`ifdef MEAS_SCAN_MAXTRACK_EN
        // Two equal peaks: the lower channel must win.
        for (int i = 0; i < N; i++) mem[i] = 24'h00FFFF;
        mem[7]  = 24'hFFFFFF;
        mem[30] = 24'hFFFFFF;
        start_scan(lat);
        wait_done(1'b0);
        chk("peak_value_direct", 32'(omax), 32'hFFFFFF);
        chk("peak_index_direct", 32'(omax_idx), 7);
`endif

        // Asynchronous reset while holding a beat in OUTPUT.
        fill_ramp();
        rdy_mode = 2;
        start_scan(lat);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_sel", 32'(sel), 0);
        chk("arst_data", 32'(data), 0);
        chk("arst_idx", 32'(idx), 0);
        chk("arst_busy", 32'(busy), 0);
        expq.delete();
        step();
        step();
        rst = 1'b0;
        rdy_mode = 0;
        repeat (20) step();
        chk("post_rst_no_valid", 32'(valid), 0);
        chk("post_rst_idle", 32'(busy), 0);

        // Zero-settle instance: latency and full beat order.
        start0 = 1'b1;
        lat = 0;
        do begin
            step();
            start0 = 1'b0;
            lat++;
        end while (!valid0 && lat < 20);
        chk("s0_first_valid_latency", lat, 2);
        cnt = 0;
        d0 = 0;
        n = 0;
        while (n < 500 && d0 == 0) begin
            if (valid0) begin
                if (cnt < N) begin
                    chk("s0_idx", 32'(idx0), cnt);
                    chk("s0_data", 32'(data0), 32'(mem[cnt]));
                end
                cnt++;
            end
            if (done0) d0++;
            step();
            n++;
        end
        repeat (4) begin
            if (done0) d0++;
            step();
        end
        chk("s0_beats", cnt, N);
        chk("s0_done_pulses", d0, 1);
        chk("s0_idle", 32'(busy0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
